// File: rtl/ad9826_pkg.sv
// Shared types for the AD9826 configuration sequencer: FSM states, register
// addresses and the engine command-word layout.
package ad9826_pkg;

  typedef enum logic [2:0] {
    S_STARTUP,
    S_LOAD,
    S_START,
    S_RDWAIT,
    S_RDACK,
    S_DONE,
    S_NEXT,
    S_IDLE
  } state_t;

  localparam logic [2:0] ADDR_CONFIG = 3'd0;
  localparam logic [2:0] ADDR_MUX    = 3'd1;
  localparam logic [2:0] ADDR_PGA_R  = 3'd2;
  localparam logic [2:0] ADDR_PGA_G  = 3'd3;
  localparam logic [2:0] ADDR_PGA_B  = 3'd4;
  localparam logic [2:0] ADDR_OFFS_R = 3'd5;
  localparam logic [2:0] ADDR_OFFS_G = 3'd6;
  localparam logic [2:0] ADDR_OFFS_B = 3'd7;

  localparam int CW_RW       = 15;
  localparam int CW_ADDR_LSB = 12;
  localparam int CW_DATA_W   = 9;

  // Reads carry no payload, so the data field is zeroed for them.
  function automatic logic [15:0] make_cfg_word(input logic rw, input logic [2:0] addr,
                                                input logic [8:0] data);
    logic [15:0] w;
    w = '0;
    w[CW_RW] = rw;
    w[CW_ADDR_LSB +: 3] = addr;
    w[CW_DATA_W-1:0] = rw ? 9'h000 : data;
    return w;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single level signal crossing into clk.
// Latency: 2 clk cycles; no backpressure.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ad9826_sequencer.sv
// AD9826 config-port master: writes the init table after reset, then serves host
// read/write requests one at a time; host waits on host_ready/host_ack. AD9826_READBACK_VERIFY_EN adds verify reads.
module ad9826_sequencer
  import ad9826_pkg::*;
#(
  parameter int         STARTUP_CYCLES = 1000,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [8:0] INIT_R0 = 9'h0C8,
  parameter logic [8:0] INIT_R1 = 9'h0C0,
  parameter logic [8:0] INIT_R2 = 9'h000,
  parameter logic [8:0] INIT_R3 = 9'h000,
  parameter logic [8:0] INIT_R4 = 9'h000,
  parameter logic [8:0] INIT_R5 = 9'h000,
  parameter logic [8:0] INIT_R6 = 9'h000,
  parameter logic [8:0] INIT_R7 = 9'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_req,
  input  logic        host_rw,
  input  logic [2:0]  host_addr,
  input  logic [8:0]  host_wdata,
  output logic        host_ready,
  output logic        host_ack,
  output logic [8:0]  host_rdata,
  output logic        init_done,
  output logic        error,
  output logic [15:0] cfg_word,
  output logic        cfg_toggle,
  input  logic        cfg_busy,
  input  logic        cfg_avail,
  output logic        cfg_recieved,
  input  logic [15:0] cfg_rdata
);

  localparam logic [8:0] INIT_TBL [8] = '{INIT_R0, INIT_R1, INIT_R2, INIT_R3,
                                          INIT_R4, INIT_R5, INIT_R6, INIT_R7};

  logic        busy_s, avail_s;
  state_t      state;
  logic [31:0] startup_cnt, tmo_cnt;
  logic [2:0]  idx;
  logic        serving, cur_rw;
  logic [2:0]  cur_addr;
  logic [8:0]  cur_wdata, rd_data;
  logic        init_rw, adv_init, tmo_hit;
  logic        rdata_unused;
`ifdef AD9826_READBACK_VERIFY_EN
  logic        verify_phase;
`endif

  assign rdata_unused = ^cfg_rdata[15:9];

  sync2 u_sync_busy  (.clk(clk), .rst_n(rst_n), .d(cfg_busy),  .q(busy_s));
  sync2 u_sync_avail (.clk(clk), .rst_n(rst_n), .d(cfg_avail), .q(avail_s));

  // Each table entry is a write, optionally followed by a read-back of the same address.
  always_comb begin
    init_rw  = 1'b0;
    adv_init = 1'b1;
`ifdef AD9826_READBACK_VERIFY_EN
    init_rw  = verify_phase;
    adv_init = verify_phase;
`endif
    tmo_hit = (tmo_cnt == 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_STARTUP;
      startup_cnt  <= '0;
      tmo_cnt      <= '0;
      idx          <= ADDR_CONFIG;
      serving      <= 1'b0;
      cur_rw       <= 1'b0;
      cur_addr     <= '0;
      cur_wdata    <= '0;
      rd_data      <= '0;
      cfg_word     <= '0;
      cfg_toggle   <= 1'b0;
      cfg_recieved <= 1'b0;
      host_ready   <= 1'b0;
      host_ack     <= 1'b0;
      host_rdata   <= '0;
      init_done    <= 1'b0;
      error        <= 1'b0;
`ifdef AD9826_READBACK_VERIFY_EN
      verify_phase <= 1'b0;
`endif
    end else begin
      cfg_toggle <= 1'b0;
      host_ack   <= 1'b0;
      case (state)
        S_STARTUP: begin
          if (startup_cnt >= 32'(STARTUP_CYCLES - 1)) begin
            idx     <= ADDR_CONFIG;
            serving <= 1'b0;
            state   <= S_LOAD;
          end else begin
            startup_cnt <= startup_cnt + 32'd1;
          end
        end
        S_LOAD: begin
          cfg_word   <= serving ? make_cfg_word(cur_rw, cur_addr, cur_wdata)
                                : make_cfg_word(init_rw, idx, INIT_TBL[idx]);
          cfg_toggle <= 1'b1;
          tmo_cnt    <= 32'(TIMEOUT_CYCLES - 1);
          rd_data    <= '0;
          state      <= S_START;
        end
        S_START, S_RDWAIT, S_RDACK, S_DONE: begin
          // A stuck engine must not hang init or the host, so expiry still finishes the item.
          if (tmo_hit) begin
            error        <= 1'b1;
            cfg_recieved <= 1'b0;
            rd_data      <= '0;
            state        <= S_NEXT;
          end else begin
            tmo_cnt <= tmo_cnt - 32'd1;
            case (state)
              S_START:  if (busy_s) state <= cfg_word[CW_RW] ? S_RDWAIT : S_DONE;
              S_RDWAIT: if (avail_s) begin
                rd_data      <= cfg_rdata[CW_DATA_W-1:0];
                cfg_recieved <= 1'b1;
                state        <= S_RDACK;
              end
              S_RDACK:  if (!avail_s) begin
                cfg_recieved <= 1'b0;
                state        <= S_DONE;
              end
              S_DONE:   if (!busy_s) state <= S_NEXT;
              default:  ;
            endcase
          end
        end
        S_NEXT: begin
          if (serving) begin
            host_ack   <= 1'b1;
            if (cur_rw) host_rdata <= rd_data;
            serving    <= 1'b0;
            host_ready <= 1'b1;
            state      <= S_IDLE;
          end else begin
`ifdef AD9826_READBACK_VERIFY_EN
            if (verify_phase && (rd_data != INIT_TBL[idx])) error <= 1'b1;
            verify_phase <= !verify_phase;
`endif
            if (!adv_init) begin
              state <= S_LOAD;
            end else if (idx == ADDR_OFFS_B) begin
              init_done  <= 1'b1;
              host_ready <= 1'b1;
              state      <= S_IDLE;
            end else begin
              idx   <= idx + 3'd1;
              state <= S_LOAD;
            end
          end
        end
        S_IDLE: begin
          if (host_req) begin
            host_ready <= 1'b0;
            serving    <= 1'b1;
            cur_rw     <= host_rw;
            cur_addr   <= host_addr;
            cur_wdata  <= host_wdata;
            state      <= S_LOAD;
          end
        end
        default: state <= S_STARTUP;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9826_sequencer.sv
// Directed bench for ad9826_sequencer with a behavioural serial-config engine model.
module tb_ad9826_sequencer;

  localparam int STARTUP = 40;
  localparam int TIMEOUT = 64;
  localparam int FRAME   = 20;
`ifdef AD9826_READBACK_VERIFY_EN
  localparam int NTX  = 16;
  localparam int IDX4 = 8;
`else
  localparam int NTX  = 8;
  localparam int IDX4 = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_req, host_rw;
  logic [2:0]  host_addr;
  logic [8:0]  host_wdata;
  logic        host_ready, host_ack, init_done, error;
  logic [8:0]  host_rdata;
  logic [15:0] cfg_word, cfg_rdata;
  logic        cfg_toggle, cfg_busy, cfg_avail, cfg_recieved;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          fall_cyc = 0;
  logic [15:0] words[$];
  logic [8:0]  shadow[8];
  logic        mute = 1'b0;
  logic        corrupt = 1'b0;
  logic        recv_held = 1'b0;

  ad9826_sequencer #(.STARTUP_CYCLES(STARTUP), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_ack(host_ack), .host_rdata(host_rdata),
    .init_done(init_done), .error(error),
    .cfg_word(cfg_word), .cfg_toggle(cfg_toggle), .cfg_busy(cfg_busy),
    .cfg_avail(cfg_avail), .cfg_recieved(cfg_recieved), .cfg_rdata(cfg_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && cfg_toggle) words.push_back(cfg_word);

  // Engine model: busy rises 2 cycles after the start pulse, frame lasts FRAME cycles.
  initial begin
    logic [15:0] w;
    logic [8:0]  rv;
    int          n;
    cfg_busy = 1'b0; cfg_avail = 1'b0; cfg_rdata = '0;
    for (int i = 0; i < 8; i++) shadow[i] = '0;
    forever begin
      @(negedge clk);
      if (rst_n && cfg_toggle && !mute) begin
        w = cfg_word;
        repeat (2) @(negedge clk);
        cfg_busy = 1'b1;
        repeat (FRAME) @(negedge clk);
        if (w[15]) begin
          rv = shadow[w[14:12]];
          if (corrupt && w[14:12] == 3'd1) rv = rv ^ 9'h001;
          cfg_rdata = {7'b0, rv};
          cfg_avail = 1'b1;
          n = 0;
          while (!cfg_recieved && rst_n && n < 100) begin @(negedge clk); n++; end
          recv_held = cfg_recieved;
          repeat (3) begin @(negedge clk); if (!cfg_recieved) recv_held = 1'b0; end
          cfg_avail = 1'b0;
        end else begin
          shadow[w[14:12]] = w[8:0];
        end
        repeat (2) @(negedge clk);
        cfg_busy = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_cfg_word"},     cfg_word,            16'h0000);
    check({pfx, "_cfg_toggle"},   16'(cfg_toggle),     16'h0);
    check({pfx, "_cfg_recieved"}, 16'(cfg_recieved),   16'h0);
    check({pfx, "_host_ready"},   16'(host_ready),     16'h0);
    check({pfx, "_host_ack"},     16'(host_ack),       16'h0);
    check({pfx, "_host_rdata"},   16'(host_rdata),     16'h0);
    check({pfx, "_init_done"},    16'(init_done),      16'h0);
    check({pfx, "_error"},        16'(error),          16'h0);
  endtask

  task automatic wait_init;
    int n;
    n = 0;
    while (!init_done && n < 5000) begin @(negedge clk); n++; end
  endtask

  task automatic host_txn(input logic rw, input logic [2:0] a, input logic [8:0] d,
                          output logic rdy_fell, output int acks, output logic [8:0] rdat,
                          output int lat);
    int n;
    @(negedge clk);
    host_req = 1'b1; host_rw = rw; host_addr = a; host_wdata = d;
    @(negedge clk);
    rdy_fell = !host_ready;
    n = 0;
    while (!host_ack && n < 2000) begin @(negedge clk); n++; end
    acks = host_ack ? 1 : 0;
    rdat = host_rdata;
    lat  = cyc - fall_cyc;
    host_req = 1'b0;
    @(negedge clk);
    if (host_ack) acks++;
  endtask

  initial begin
    logic        rdy_fell;
    logic [8:0]  rdat;
    int          acks, lat, n;
    logic [15:0] exp_wr[8];
    logic [15:0] exp_rd[8];
    exp_wr = '{16'h00C8, 16'h10C0, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000, 16'h7000};
    exp_rd = '{16'h8000, 16'h9000, 16'hA000, 16'hB000, 16'hC000, 16'hD000, 16'hE000, 16'hF000};

    rst_n = 1'b0; host_req = 1'b0; host_rw = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");

    // First start pulse exactly STARTUP+1 cycles after reset release.
    rst_n = 1'b1;
    n = 0;
    while (n < STARTUP + 50) begin
      @(posedge clk); #1; n++;
      if (cfg_toggle) break;
    end
    check("first_toggle_cycle", 16'(n), 16'(STARTUP + 1));

    wait_init();
    check("init_done", 16'(init_done), 16'h1);
    check("init_ready", 16'(host_ready), 16'h1);
    check("init_error", 16'(error), 16'h0);
    check("init_count", 16'(words.size()), 16'(NTX));
    for (int i = 0; i < 8; i++) begin
`ifdef AD9826_READBACK_VERIFY_EN
      check($sformatf("init_wr%0d", i), words[2*i], exp_wr[i]);
      check($sformatf("init_vr%0d", i), words[2*i+1], exp_rd[i]);
`else
      check($sformatf("init_wr%0d", i), words[i], exp_wr[i]);
`endif
    end

    // Host write.
    words.delete();
    host_txn(1'b0, 3'd3, 9'h1A5, rdy_fell, acks, rdat, lat);
    check("wr_ready_fell", 16'(rdy_fell), 16'h1);
    check("wr_word", words[0], 16'h31A5);
    check("wr_count", 16'(words.size()), 16'd1);
    check("wr_acks", 16'(acks), 16'd1);
    check("wr_lat_ok", 16'(lat >= 2 && lat <= 4), 16'h1);
    check("wr_error", 16'(error), 16'h0);
    check("wr_shadow", 16'(shadow[3]), 16'h1A5);

    // Host read.
    words.delete();
    shadow[5] = 9'h0F3;
    host_txn(1'b1, 3'd5, 9'h000, rdy_fell, acks, rdat, lat);
    check("rd_word", words[0], 16'hD000);
    check("rd_acks", 16'(acks), 16'd1);
    check("rd_rdata", 16'(rdat), 16'h0F3);
    check("rd_recv_held", 16'(recv_held), 16'h1);
    check("rd_recv_low", 16'(cfg_recieved), 16'h0);
    check("rd_lat_ok", 16'(lat >= 2 && lat <= 4), 16'h1);
    check("rd_rdata_hold", 16'(host_rdata), 16'h0F3);

    // Engine never responds: every item times out, init still completes.
    mute = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); words.delete(); rst_n = 1'b1;
    wait_init();
    check("to_init_done", 16'(init_done), 16'h1);
    check("to_error", 16'(error), 16'h1);
    check("to_count", 16'(words.size()), 16'(NTX));
    check("to_ready", 16'(host_ready), 16'h1);
    host_txn(1'b1, 3'd2, 9'h000, rdy_fell, acks, rdat, lat);
    check("to_rd_acks", 16'(acks), 16'd1);
    check("to_rd_rdata", 16'(rdat), 16'h000);

    // Reset during table item 4 restarts the table from address 0.
    mute = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); words.delete(); rst_n = 1'b1;
    n = 0;
    while (words.size() < IDX4 + 1 && n < 3000) begin @(negedge clk); n++; end
    check("mid_item4_word", words[IDX4], 16'h4000);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_reset_vals("mid");
    repeat (3) @(negedge clk);
    words.delete();
    rst_n = 1'b1;
    wait_init();
    check("mid_restart_word0", words[0], 16'h00C8);
    check("mid_restart_count", 16'(words.size()), 16'(NTX));
    check("mid_init_done", 16'(init_done), 16'h1);

`ifdef AD9826_READBACK_VERIFY_EN
    // Wrong read-back for address 1 flags an error.
    corrupt = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); words.delete(); rst_n = 1'b1;
    wait_init();
    check("vfy_init_done", 16'(init_done), 16'h1);
    check("vfy_error", 16'(error), 16'h1);
    check("vfy_count", 16'(words.size()), 16'd16);
    corrupt = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ad9826_sequencer.md
# ad9826_sequencer

Controller that owns the AD9826 serial configuration port on the CDIP24 readout board. After reset it writes a fixed eight-register initialisation table to the ADC, then serves single read/write requests from the host command decoder. It drives the existing serial-config engine through that engine's `toggle`/`busy`/`config_out_avail`/`config_out_recieved` handshake and is the only master of that engine.

## Interface
- `STARTUP_CYCLES`, default 1000: `clk` cycles to wait after reset release before the first write.
- `TIMEOUT_CYCLES`, default 4096: maximum `clk` cycles allowed for any one transaction.
- `INIT_R0` … `INIT_R7`, defaults 9'h0C8, 9'h0C0, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000: data values written to AD9826 addresses 0–7.
- `clk` in 1: system clock. One clock for the whole block.
- `rst_n` in 1: asynchronous, active-low reset.
- `host_req` in 1: host requests a transaction. Held until `host_ack`.
- `host_rw` in 1: 1 = read, 0 = write.
- `host_addr` in 3: AD9826 register address.
- `host_wdata` in 9: write data.
- `host_ready` out 1: initialisation is complete and the block is idle.
- `host_ack` out 1: one-cycle pulse when the transaction has finished.
- `host_rdata` out 9: read data. Valid with `host_ack` for reads and held until the next ack.
- `init_done` out 1: sticky flag; the initialisation table has been written.
- `error` out 1: sticky flag; a timeout (or verify mismatch) occurred. Cleared only by reset.
- `cfg_word` out 16: to the engine. Layout is rw[15], addr[14:12], 3'b000[11:9], data[8:0].
- `cfg_toggle` out 1: one-cycle start pulse to the engine.
- `cfg_busy` in 1: engine busy. Asynchronous to `clk` (engine runs on `ad_clk`).
- `cfg_avail` in 1: engine read data available. Asynchronous.
- `cfg_recieved` out 1: read data accepted.
- `cfg_rdata` in 16: engine readback word. Stable while `cfg_avail` is high.

## Operation
- `cfg_busy` and `cfg_avail` each pass through a 2-flop synchroniser before use. `cfg_rdata` is sampled only when the synchronised `cfg_avail` is high.
- States:
  - **S_STARTUP**: count `STARTUP_CYCLES`, then go to S_LOAD with index = 0.
  - **S_LOAD**: drive `cfg_word` for the current item and pulse `cfg_toggle` for one cycle. Go to S_START.
  - **S_START**: wait for busy to rise. Go to S_DONE for a write, S_RDWAIT for a read.
  - **S_RDWAIT**: wait for avail. Capture `cfg_rdata[8:0]`, assert `cfg_recieved`, go to S_RDACK.
  - **S_RDACK**: hold `cfg_recieved` until avail falls. Go to S_DONE.
  - **S_DONE**: wait for busy to fall, then go to S_NEXT.
  - **S_NEXT**:
    - If initialising and index < 7: increment the index, go to S_LOAD.
    - If initialising and index = 7: set `init_done`, go to S_IDLE.
    - If serving the host: pulse `host_ack`, go to S_IDLE.
  - **S_IDLE**: `host_ready` = 1. When `host_req` is seen, latch rw/addr/wdata, go to S_LOAD.
- `cfg_word` is registered and held constant from S_LOAD until S_NEXT, because the engine reads it bit-serially.
- The timeout counter reloads in S_LOAD and runs in S_START, S_RDWAIT, S_RDACK and S_DONE. On expiry:
  - set `error` and drop `cfg_recieved`;
  - go to S_NEXT, so initialisation continues and a host transaction still acks, with `host_rdata` = 0.
- `host_req` is ignored outside S_IDLE. A request made during initialisation waits and is served after `init_done`.
- Reset mid-transaction returns the block to S_STARTUP and re-runs the whole table. The engine finishes its current frame on its own.

## Timing
- Reset values:
  - `cfg_word` = 0, `cfg_toggle` = 0, `cfg_recieved` = 0;
  - `host_ready` = 0, `host_ack` = 0, `host_rdata` = 0;
  - `init_done` = 0, `error` = 0.
- The first `cfg_toggle` occurs `STARTUP_CYCLES` + 1 cycles after `rst_n` rises.
- `host_ready` falls in the cycle after `host_req` is accepted. `host_ack` is asserted in exactly one cycle.
- The synchronisers add a 2-cycle lag on every engine edge. The bench therefore accepts ack latency = engine frame + 2..4 `clk` cycles.
- The next `cfg_toggle` is at least 1 cycle after synchronised busy is seen low.

## Configuration
- `AD9826_READBACK_VERIFY_EN` defined:
  - after each initialisation write, the block issues a read of the same address;
  - if the 9-bit result differs from the table value, it sets `error`;
  - the index advances only after the verify read.
- Undefined: writes only; no verify reads are issued.

## Structure
- Shared package `ad9826_pkg` holds:
  - the state enum;
  - the register address constants (CONFIG = 0, MUX = 1, PGA_R/G/B = 2..4, OFFS_R/G/B = 5..7);
  - the cfg_word field positions.
- One sub-module, `sync2`: the 2-flop synchroniser, instantiated twice.

## Test plan
- Reset, with the engine model acking after 20 cycles → eight writes: cfg_word 16'h00C8, 16'h10C0, 16'h2000 … 16'h7000 in order, then `init_done` = 1 and `host_ready` = 1.
- Host write, addr 3, wdata 9'h1A5 → cfg_word 16'h31A5, one `host_ack`, `error` = 0.
- Host read, addr 5, model returns 9'h0F3 → cfg_word 16'hD000, `cfg_recieved` high until avail falls, `host_rdata` = 9'h0F3 with `host_ack`.
- Model never raises busy → after `TIMEOUT_CYCLES`, `error` = 1 and the sequence continues to `init_done`.
- `rst_n` pulsed low during table item 4 → all outputs return to reset values, and the sequence restarts at addr 0.
- With `AD9826_READBACK_VERIFY_EN` defined, model returns a wrong value for addr 1 → `error` = 1, 16 transactions total.
